// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit counters.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } sw_state_e;

endpackage

// File: rtl/bcd_digit.sv
// Single decimal digit counter: holds 0..9, wraps 9 -> 0 on inc, clr has priority.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] val,
  output logic             at_max
);

  logic [BCD_W-1:0] val_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else if (clr) begin
      val_q <= '0;
    end else if (inc) begin
      val_q <= (val_q == BCD_MAX) ? '0 : val_q + BCD_W'(1);
    end
  end

  assign val    = val_q;
  assign at_max = (val_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaled tick feeding a cascade of BCD digits.
// Optional display hold (lap) enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned PRESCALE   = 100000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop,
  input  logic                    clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);

  sw_state_e state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic running_q, overflow_q;
  logic tick;

  logic [NUM_DIGITS-1:0]   at_max;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] live;

  assign tick = (state_q == StRun) && (p_q == PLast);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle:  if (start_stop) state_d = StRun;
      StRun:   if (start_stop) state_d = StPause;
      StPause: if (start_stop) state_d = StRun;
      default: state_d = StIdle;
    endcase
    if (state_q == StRun) begin
      p_d = tick ? '0 : p_q + PW'(1);
    end
    if (clear) begin
      state_d = StIdle;
      p_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      p_q        <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      running_q  <= (state_d == StRun);
      overflow_q <= !clear && carry[NUM_DIGITS];
    end
  end

  // carry[i] is the increment enable of digit i; carry[NUM_DIGITS] means all-9s wrap.
  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign carry[g+1] = carry[g] & at_max[g];

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .inc    (carry[g]),
      .val    (live[g*4 +: 4]),
      .at_max (at_max[g])
    );
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                    hold_q;
  logic [4*NUM_DIGITS-1:0] snap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (clear) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q != StIdle)) begin
      hold_q <= !hold_q;
      if (!hold_q) snap_q <= live;
    end
  end

  assign digits = hold_q ? snap_q : live;
`else
  assign digits = live;
`endif

  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random pulses vs. a decimal model.
module tb_stopwatch_ctrl;

  localparam int PS   = 4;
  localparam int ND   = 2;
  localparam int MAXC = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic [4*ND-1:0]   digits;
  logic              running;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: count as a plain integer, prescale phase as an integer.
  int m_cnt, m_p, m_snap;
  bit m_active, m_run, m_ovf, m_hold;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  stopwatch_ctrl #(
    .PRESCALE   (PS),
    .NUM_DIGITS (ND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int d;
    d = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_p = 0; m_snap = 0;
    m_active = 0; m_run = 0; m_ovf = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit ss, input bit cl, input bit lp);
    bit tk;
    if (cl) begin
      model_reset();
      return;
    end
    tk    = m_run && (m_p == PS - 1);
    m_ovf = tk && (m_cnt == MAXC - 1);
    if (m_run) m_p = tk ? 0 : m_p + 1;
    if (LapEn && lp && m_active) begin
      if (!m_hold) m_snap = m_cnt;
      m_hold = !m_hold;
    end
    if (tk) m_cnt = (m_cnt + 1) % MAXC;
    if (ss) begin
      if (!m_active) begin
        m_active = 1;
        m_run    = 1;
      end else begin
        m_run = !m_run;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("digits", 32'(digits), 32'(to_bcd(m_hold ? m_snap : m_cnt)));
    check_eq("running", 32'(running), 32'(m_run));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit ss, input bit cl, input bit lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    model_step(ss, cl, lp);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    check_outputs();
  endtask

  // Advance until the model count equals target (optionally also on the tick cycle).
  task automatic run_until(input int target, input bit on_tick);
    int n;
    n = 0;
    while (!(m_cnt == target && (!on_tick || (m_run && m_p == PS - 1))) && n < 1000) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 1000) check_eq("run_until_timeout", 32'(m_cnt), 32'(target));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_digits", 32'(digits), 32'h0);
    check_eq("rst_running", 32'(running), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);

    // Start and first ticks.
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("start_running", 32'(running), 32'h1);
    repeat (PS) cycle(1'b0, 1'b0, 1'b0);
    check_eq("first_tick", 32'(digits), 32'h01);
    repeat (PS) cycle(1'b0, 1'b0, 1'b0);
    check_eq("second_tick", 32'(digits), 32'h02);

    // Carry 09 -> 10.
    run_until(9, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("carry_10", 32'(digits), 32'h10);

    // Wrap 99 -> 00 with a single overflow pulse.
    run_until(99, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("wrap_digits", 32'(digits), 32'h00);
    check_eq("wrap_overflow", 32'(overflow), 32'h1);
    check_eq("wrap_running", 32'(running), 32'h1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("overflow_one_cycle", 32'(overflow), 32'h0);

    // Pause on a tick cycle, then pause mid-period and resume from the held phase.
    run_until(5, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("pause_on_tick", 32'(digits), 32'h06);
    check_eq("pause_running", 32'(running), 32'h0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    check_eq("pause_frozen", 32'(digits), 32'h06);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("resume_before", 32'(digits), 32'h06);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("resume_remainder", 32'(digits), 32'h07);

    // clear beats start_stop.
    run_until(37, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("clear_digits", 32'(digits), 32'h00);
    check_eq("clear_running", 32'(running), 32'h0);

    // Asynchronous reset mid-run; no counting until a new start.
    cycle(1'b1, 1'b0, 1'b0);
    run_until(23, 1'b0);
    async_reset();
    repeat (2 * PS) cycle(1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_HOLD_EN
    cycle(1'b1, 1'b0, 1'b0);
    run_until(12, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    run_until(14, 1'b0);
    check_eq("lap_hold", 32'(digits), 32'h12);
    run_until(15, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("lap_release", 32'(digits), 32'h15);
    cycle(1'b0, 1'b1, 1'b0);
`endif

    // Random pulses; occasional mid-cycle reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 11) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
